// File: rtl/drt_enumerator_if.sv
// drt_enumerator_if: wishbone read-master bus between the DRT enumerator and the ROM table slave
//   wbm_cyc_o/wbm_stb_o : cycle and strobe, high for the whole of one single-word read
//   wbm_we_o            : write enable, never asserted by the enumerator
//   wbm_adr_o           : word address of the read
//   wbm_dat_o           : write data, unused and held at 0
//   wbm_dat_i           : read data returned by the slave
//   wbm_ack_i           : slave acknowledge, qualifies wbm_dat_i
interface drt_enumerator_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );
  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/drt_enumerator.sv
// drt_enumerator: walks a device ROM table over wishbone and streams one record per device
//   clk, rst        : rising-edge clock, asynchronous active-low reset
//   start           : one-cycle request to enumerate, honoured only when idle
//   busy/done/error : walk in progress, one-cycle completion pulse, sticky abort flag
//   wb              : wishbone read master (drt_enumerator_if.master)
//   drt_version/id  : header word 0 high/low halves
//   num_devices     : header word 1 as read, unclamped
//   dev_valid/ready : record stream handshake
//   dev_index       : zero-based index of the presented record
//   dev_id/flags/offset/size : the four words of the presented record
module drt_enumerator #(
  parameter logic [31:0] DRT_BASE    = 32'h0,
  parameter int          MAX_DEVICES = 16,
  parameter int          TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  drt_enumerator_if.master         wb,
  output logic [15:0]              drt_version,
  output logic [15:0]              drt_id,
  output logic [31:0]              num_devices,
  output logic                     dev_valid,
  input  logic                     dev_ready,
  output logic [7:0]               dev_index,
  output logic [31:0]              dev_id,
  output logic [31:0]              dev_flags,
  output logic [31:0]              dev_offset,
  output logic [31:0]              dev_size
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, GAP, EMIT, FINISH} state_t;
  localparam logic [31:0] MAXD = 32'(MAX_DEVICES);
  state_t      state, state_nx;
  logic [31:0] off;
  logic [31:0] tmo;
  logic [7:0]  last;
  logic        rd;
  // Index of the final record to emit; only meaningful when the clamped count is non-zero.
  assign last = (num_devices > MAXD ? MAXD[7:0] : num_devices[7:0]) - 8'd1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? RD_REQ : IDLE;
      RD_REQ:  state_nx = RD_WAIT;
      RD_WAIT: state_nx = wb.wbm_ack_i ? GAP : (tmo == 32'd1 ? FINISH : RD_WAIT);
      // off still names the word just captured: header word 1 decides whether any entry is walked,
      // and the size word (offset ending in 3) completes a record.
      GAP:     state_nx = (off == 32'd1 && num_devices == 32'd0) ? FINISH : (off[1:0] == 2'd3 ? EMIT : RD_REQ);
      EMIT:    state_nx = dev_ready ? (dev_index == last ? FINISH : RD_REQ) : EMIT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy      = state != IDLE && state != FINISH;
    done      = state == FINISH;
    dev_valid = state == EMIT;
    rd        = state == RD_REQ || state == RD_WAIT;
  end
  assign wb.wbm_cyc_o = rd;
  assign wb.wbm_stb_o = rd;
  assign wb.wbm_we_o  = 1'b0;
  assign wb.wbm_dat_o = 32'd0;
  assign wb.wbm_adr_o = rd ? DRT_BASE + off : 32'd0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      off         <= '0;
      tmo         <= '0;
      error       <= 1'b0;
      drt_version <= '0;
      drt_id      <= '0;
      num_devices <= '0;
      dev_index   <= '0;
      dev_id      <= '0;
      dev_flags   <= '0;
      dev_offset  <= '0;
      dev_size    <= '0;
    end else begin
      if (state == IDLE && start) begin
        off       <= '0;
        error     <= 1'b0;
        dev_index <= '0;
      end
      if (state == RD_REQ) tmo <= 32'(TIMEOUT);
      if (state == RD_WAIT) begin
        tmo <= tmo - 32'd1;
        if (wb.wbm_ack_i) begin
          if (off == 32'd0) {drt_version, drt_id} <= wb.wbm_dat_i;
          else if (off == 32'd1) begin
            num_devices <= wb.wbm_dat_i;
            if (wb.wbm_dat_i > MAXD) error <= 1'b1;
          end else begin
            case (off[1:0])
              2'd0:    dev_id     <= wb.wbm_dat_i;
              2'd1:    dev_flags  <= wb.wbm_dat_i;
              2'd2:    dev_offset <= wb.wbm_dat_i;
              default: dev_size   <= wb.wbm_dat_i;
            endcase
          end
        end else if (tmo == 32'd1) error <= 1'b1;
      end
      // Header words 2 and 3 are skipped; a completed record holds its offset until emitted.
      if (state == GAP) off <= off == 32'd1 ? 32'd4 : (off[1:0] == 2'd3 ? off : off + 32'd1);
      if (state == EMIT && dev_ready && dev_index != last) begin
        off       <= off + 32'd1;
        dev_index <= dev_index + 8'd1;
      end
    end
  end
endmodule
